ram_port_arbiter: RTL

Shares the single physical RAM port between two bus masters: requester A (the CPU memory controller) and requester B (a DMA/boot-loader engine).
- Grants one transaction at a time, round-robin on contention.
- Drives the physical RAM request strobes, waits a fixed read latency, captures read data and returns it to the owner with a one-cycle done pulse.
- Sits between the memory controller's physical-side outputs and the top-level physical RAM pins.

---
 rtl/ram_port_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/ram_port_arbiter.sv
// Two-master arbiter for the single physical RAM port: round-robin grant,
// one transaction in flight, fixed read latency, one-cycle done pulse to the owner.
module ram_port_arbiter #(
    parameter int RAM_LATENCY = 2   // legal range 1..15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] aRamAddress,
    input  logic [31:0] aRamWrite,
    input  logic        aReadReq,
    input  logic        aWriteReq,
    output logic [31:0] aRamRead,
    output logic        aDone,
    input  logic [31:0] bRamAddress,
    input  logic [31:0] bRamWrite,
    input  logic        bReadReq,
    input  logic        bWriteReq,
    output logic [31:0] bRamRead,
    output logic        bDone,
    input  logic [31:0] phRamRead,
    output logic [31:0] phRamAddress,
    output logic [31:0] phRamWrite,
    output logic        phReadReq,
    output logic        phWriteReq,
    output logic [1:0]  arbState
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } stateT;

    typedef struct packed {
        logic        isWrite;
        logic [31:0] addr;
        logic [31:0] data;
    } reqT;

    stateT      state;
    logic       owner;      // 0 = A, 1 = B
    logic       lastGrant;  // 0 = A, 1 = B
    logic       opWrite;
    logic [3:0] waitCnt;

    logic aPending;
    logic bPending;
    logic grantB;
    reqT  selReq;

    // Read wins when both strobes are raised by the same requester.
    always_comb begin
        aPending = aReadReq | aWriteReq;
        bPending = bReadReq | bWriteReq;
        grantB   = bPending & (~aPending | ~lastGrant);
        if (grantB) begin
            selReq.isWrite = bWriteReq & ~bReadReq;
            selReq.addr    = bRamAddress;
            selReq.data    = bRamWrite;
        end else begin
            selReq.isWrite = aWriteReq & ~aReadReq;
            selReq.addr    = aRamAddress;
            selReq.data    = aRamWrite;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            owner        <= 1'b0;
            lastGrant    <= 1'b1;
            opWrite      <= 1'b0;
            waitCnt      <= 4'd0;
            phReadReq    <= 1'b0;
            phWriteReq   <= 1'b0;
            phRamAddress <= 32'd0;
            phRamWrite   <= 32'd0;
            aDone        <= 1'b0;
            bDone        <= 1'b0;
            aRamRead     <= 32'd0;
            bRamRead     <= 32'd0;
        end else begin
            phReadReq  <= 1'b0;
            phWriteReq <= 1'b0;
            aDone      <= 1'b0;
            bDone      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (aPending | bPending) begin
                        // Address/data registers double as the transaction latch.
                        owner        <= grantB;
                        lastGrant    <= grantB;
                        opWrite      <= selReq.isWrite;
                        phRamAddress <= selReq.addr;
                        phRamWrite   <= selReq.data;
                        phReadReq    <= ~selReq.isWrite;
                        phWriteReq   <= selReq.isWrite;
                        state        <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (opWrite) begin
                        aDone <= ~owner;
                        bDone <= owner;
                        state <= ST_DONE;
                    end else begin
                        waitCnt <= 4'(RAM_LATENCY);
                        state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    waitCnt <= waitCnt - 4'd1;
                    if (waitCnt == 4'd1) begin
                        if (owner) bRamRead <= phRamRead;
                        else       aRamRead <= phRamRead;
                        aDone <= ~owner;
                        bDone <= owner;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign arbState = state;

endmodule
